pox_multi_led_controller: RTL and testbench

- Parametrised next-generation pulse-oximeter front-end controller. Supports N_CH time-multiplexed LED channels instead of the fixed IR/RED pair.
- Keeps separate LED drive, DC compensation and PGA gain settings for each channel, and runs a per-channel auto-calibration when Find_setting rises.
- Sits between the 8-bit front-end ADC and the analog LED/PGA/DC-comp DACs. Provides per-channel ADC samples to the downstream SpO2 datapath and a divided clock for the analog filter.

---
 rtl/pox_ctrl_pkg.sv | 16 +
 rtl/pox_clk_divider.sv | 25 ++
 rtl/pox_multi_led_controller.sv | 180 ++++++++++++++++++
 tb/tb_pox_multi_led_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pox_ctrl_pkg.sv
// pox_ctrl_pkg: shared FSM states, reset codes and width helpers for the LED controller
package pox_ctrl_pkg;
  typedef enum logic [2:0] {M_ON, M_GAP, C_ON, C_EVAL, C_GAP} state_t;
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int drive_rst(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int dc_rst();
    return 0;
  endfunction
  function automatic int gain_rst();
    return 0;
  endfunction
endpackage

// File: rtl/pox_clk_divider.sv
// pox_clk_divider: free-running clock divider toggling every FILT_DIV cycles
module pox_clk_divider
  import pox_ctrl_pkg::*;
#(
  parameter int FILT_DIV = 4
) (
  input  logic CLK,
  input  logic rst_n,
  output logic CLK_Filter
);
  localparam int W = clog2(FILT_DIV);
  logic [W-1:0] cnt;
  // count FILT_DIV cycles, then flip the output
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      CLK_Filter <= 1'b0;
    end else if (cnt == W'(FILT_DIV - 1)) begin
      cnt <= '0;
      CLK_Filter <= ~CLK_Filter;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pox_multi_led_controller.sv
// pox_multi_led_controller: time-multiplexed LED sequencer with per-channel auto-calibration
module pox_multi_led_controller
  import pox_ctrl_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int ADC_W         = 8,
  parameter int DRIVE_W       = 4,
  parameter int DC_W          = 7,
  parameter int GAIN_W        = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int TARGET_LO     = 96,
  parameter int TARGET_HI     = 160,
  parameter int MAX_ITER      = 255,
  parameter int FILT_DIV      = 4
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [ADC_W-1:0]        ADC,
  input  logic                    Find_setting,
  output logic [N_CH-1:0]         LED_EN,
  output logic [DRIVE_W-1:0]      LED_DRIVE,
  output logic [DC_W-1:0]         DC_Comp,
  output logic [GAIN_W-1:0]       PGA_Gain,
  output logic                    CLK_Filter,
  output logic [N_CH*ADC_W-1:0]   ADC_Value,
  output logic [N_CH-1:0]         Value_valid,
  output logic                    Cal_busy,
  output logic                    Cal_done,
  output logic [N_CH-1:0]         Cal_fail
);
  localparam int CH_W = clog2(N_CH);
  localparam int CNT_W = clog2((SETTLE_CYCLES > GAP_CYCLES ? SETTLE_CYCLES : GAP_CYCLES) + 1);
  localparam int IT_W = clog2(MAX_ITER + 1);
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
  localparam logic [DRIVE_W-1:0] DRV_RST = DRIVE_W'(drive_rst(DRIVE_W));
  localparam logic [DC_W-1:0] DC_RST = DC_W'(dc_rst());
  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(gain_rst());
  localparam logic [DRIVE_W-1:0] DRV_MAX = '1;
  localparam logic [DC_W-1:0] DC_MAX = '1;
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  state_t state, state_n;
  logic [CH_W-1:0] ch, ch_n, slot_ch;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IT_W-1:0] iter;
  logic [ADC_W-1:0] smp;
  logic [DRIVE_W-1:0] drive [N_CH];
  logic [DC_W-1:0] dc [N_CH];
  logic [GAIN_W-1:0] gain [N_CH];
  logic [DRIVE_W-1:0] r;
  logic [DC_W-1:0] d;
  logic [GAIN_W-1:0] g;
  logic fs_q, cal_start, on_end, gap_end;
  logic ev_hi, ev_lo, ev_lock, can_adj, ev_fail, ev_adv, cal_end;
  assign cal_start = Find_setting & ~fs_q & ~Cal_busy;
  assign on_end = cnt == CNT_W'(SETTLE_CYCLES - 1);
  assign gap_end = cnt == CNT_W'(GAP_CYCLES - 1);
  assign r = drive[ch];
  assign d = dc[ch];
  assign g = gain[ch];
  assign ev_hi = smp > ADC_W'(TARGET_HI);
  assign ev_lo = smp < ADC_W'(TARGET_LO);
  assign ev_lock = !ev_hi && !ev_lo;
  assign can_adj = ev_hi ? (d != DC_MAX || r != '0) : (d != '0 || g != GAIN_MAX || r != DRV_MAX);
  assign ev_fail = !ev_lock && (!can_adj || iter == IT_W'(MAX_ITER - 1));
  assign ev_adv = ev_lock || ev_fail;
  assign cal_end = state == C_EVAL && ev_adv && ch == LAST;
  assign slot_ch = state == M_GAP ? (ch == LAST ? '0 : ch + 1'b1) : ch;
  assign LED_EN = (state == M_ON || state == C_ON) ? N_CH'(1) << ch : '0;
  // state, slot counter and channel index
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_GAP;
      cnt <= '0;
      ch <= LAST;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ch <= ch_n;
    end
  end
  // slot sequencing for measure and calibration modes
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    ch_n = ch;
    if (cal_start) begin
      state_n = C_GAP;
      cnt_n = '0;
      ch_n = '0;
    end else begin
      case (state)
        M_ON: if (on_end) begin
          state_n = M_GAP;
          cnt_n = '0;
        end
        M_GAP: if (gap_end) begin
          state_n = M_ON;
          cnt_n = '0;
          ch_n = slot_ch;
        end
        C_ON: if (on_end) begin
          state_n = C_EVAL;
          cnt_n = '0;
        end
        C_EVAL: begin
          state_n = cal_end ? M_GAP : C_GAP;
          cnt_n = '0;
          ch_n = cal_end ? LAST : ev_adv ? ch + 1'b1 : ch;
        end
        default: if (gap_end) begin
          state_n = C_ON;
          cnt_n = '0;
        end
      endcase
    end
  end
  // per-channel settings, stepped one saturating move per unlocked evaluation
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        drive[i] <= DRV_RST;
        dc[i] <= DC_RST;
        gain[i] <= GAIN_RST;
      end
    end else if (state == C_EVAL && !ev_adv && !cal_start) begin
      if (ev_hi) begin
        if (d != DC_MAX) dc[ch] <= d + 1'b1;
        else drive[ch] <= r - 1'b1;
      end else if (d != '0) dc[ch] <= d - 1'b1;
      else if (g != GAIN_MAX) gain[ch] <= g + 1'b1;
      else drive[ch] <= r + 1'b1;
    end
  end
  // samples, valid pulses and calibration status
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= 1'b0;
      ADC_Value <= '0;
      Value_valid <= '0;
      smp <= '0;
      iter <= '0;
      Cal_busy <= 1'b0;
      Cal_done <= 1'b0;
      Cal_fail <= '0;
    end else begin
      fs_q <= Find_setting;
      Value_valid <= (state == M_ON && on_end && !cal_start) ? N_CH'(1) << ch : '0;
      if (state == M_ON && on_end && !cal_start) ADC_Value[ch*ADC_W +: ADC_W] <= ADC;
      if (state == C_ON && on_end) smp <= ADC;
      Cal_done <= cal_end;
      if (cal_start) begin
        Cal_busy <= 1'b1;
        Cal_fail <= '0;
        iter <= '0;
      end else if (state == C_EVAL) begin
        iter <= ev_adv ? '0 : iter + 1'b1;
        if (ev_fail) Cal_fail[ch] <= 1'b1;
        if (cal_end) Cal_busy <= 1'b0;
      end
    end
  end
  // settings of the upcoming or active slot, ready a cycle before its LED rises
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      LED_DRIVE <= DRV_RST;
      DC_Comp <= DC_RST;
      PGA_Gain <= GAIN_RST;
    end else begin
      LED_DRIVE <= drive[slot_ch];
      DC_Comp <= dc[slot_ch];
      PGA_Gain <= gain[slot_ch];
    end
  end
  pox_clk_divider #(.FILT_DIV(FILT_DIV)) u_div (
    .CLK(CLK),
    .rst_n(rst_n),
    .CLK_Filter(CLK_Filter)
  );
endmodule

// File: tb/tb_pox_multi_led_controller.sv
// tb_pox_multi_led_controller: directed self-checking bench for the LED controller
module tb_pox_multi_led_controller;
  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  logic Find_setting = 1'b0;
  logic [7:0] ADC = 8'd100;
  logic [1:0] LED_EN, Value_valid, Cal_fail;
  logic [3:0] LED_DRIVE, PGA_Gain;
  logic [6:0] DC_Comp;
  logic [15:0] ADC_Value;
  logic CLK_Filter, Cal_busy, Cal_done;
  int checks = 0;
  int failures = 0;
  int mode = 0;
  logic [7:0] adc_const = 8'd100;

  always #5 CLK = ~CLK;

  pox_multi_led_controller dut (
    .CLK(CLK), .rst_n(rst_n), .ADC(ADC), .Find_setting(Find_setting),
    .LED_EN(LED_EN), .LED_DRIVE(LED_DRIVE), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .CLK_Filter(CLK_Filter), .ADC_Value(ADC_Value), .Value_valid(Value_valid),
    .Cal_busy(Cal_busy), .Cal_done(Cal_done), .Cal_fail(Cal_fail)
  );

  // advance to the next falling edge and refresh the ADC from the bench model
  task automatic step();
    @(negedge CLK);
    ADC = mode == 1 ? (LED_EN[0] ? 8'd50 : 8'd200) :
          mode == 2 ? 8'(200 - 2 * int'(DC_Comp)) : adc_const;
  endtask

  task automatic start_cal();
    Find_setting = 1'b1;
    step();
    Find_setting = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] exp_led [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    #1 rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({LED_EN, Value_valid, Cal_busy, Cal_done, Cal_fail, CLK_Filter} !== 10'b0 || ADC_Value !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got led=%b vv=%b busy=%b done=%b fail=%b filt=%b adc=%h want all zero",
               LED_EN, Value_valid, Cal_busy, Cal_done, Cal_fail, CLK_Filter, ADC_Value);
    end
    checks++;
    if (LED_DRIVE !== 4'd8 || DC_Comp !== 7'd0 || PGA_Gain !== 4'd0) begin
      failures++;
      $display("FAIL reset_settings got drive=%0d dc=%0d gain=%0d want 8 0 0", LED_DRIVE, DC_Comp, PGA_Gain);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (LED_EN !== exp_led[i]) begin
        failures++;
        $display("FAIL start_led[%0d] got %b want %b", i, LED_EN, exp_led[i]);
      end
      checks++;
      if (Value_valid !== (i == 5 ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL start_valid[%0d] got %b want %b", i, Value_valid, (i == 5 ? 2'b01 : 2'b00));
      end
      checks++;
      if (CLK_Filter !== 1'(((i + 1) / 4) % 2)) begin
        failures++;
        $display("FAIL filt_clk[%0d] got %b want %0d", i, CLK_Filter, ((i + 1) / 4) % 2);
      end
      if (i == 5) begin
        checks++;
        if (ADC_Value[7:0] !== 8'd100) begin
          failures++;
          $display("FAIL start_sample got %0d want 100", ADC_Value[7:0]);
        end
      end
    end
    checks++;
    if (LED_DRIVE !== 4'd8 || DC_Comp !== 7'd0 || PGA_Gain !== 4'd0) begin
      failures++;
      $display("FAIL run_settings got drive=%0d dc=%0d gain=%0d want 8 0 0", LED_DRIVE, DC_Comp, PGA_Gain);
    end
  endtask

  task automatic test_measure();
    int last = -1;
    int pulses = 0;
    logic [1:0] lastv = 2'b00;
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Value_valid != 2'b00) begin
        pulses++;
        checks++;
        if (Value_valid == 2'b01 ? ADC_Value[7:0] !== 8'd50 :
            Value_valid == 2'b10 ? ADC_Value[15:8] !== 8'd200 : 1'b1) begin
          failures++;
          $display("FAIL meas_sample vv=%b got ch0=%0d ch1=%0d want 50/200", Value_valid, ADC_Value[7:0], ADC_Value[15:8]);
        end
        if (last >= 0) begin
          checks++;
          if (i - last != 6 || Value_valid === lastv) begin
            failures++;
            $display("FAIL meas_period got gap=%0d vv=%b prev=%b want 6 alternating", i - last, Value_valid, lastv);
          end
        end
        last = i;
        lastv = Value_valid;
      end
    end
    checks++;
    if (pulses < 6) begin
      failures++;
      $display("FAIL meas_pulses got %0d want >=6", pulses);
    end
  endtask

  task automatic test_cal_lock();
    int n = 0;
    logic seen_vv = 1'b0;
    mode = 0;
    adc_const = 8'd130;
    for (int i = 0; i < 20 && LED_EN == 2'b00; i++) step();
    step();
    checks++;
    if (LED_EN === 2'b00) begin
      failures++;
      $display("FAIL lock_led_on got %b want nonzero", LED_EN);
    end
    start_cal();
    checks++;
    if (LED_EN !== 2'b00 || Cal_busy !== 1'b1) begin
      failures++;
      $display("FAIL lock_abort got led=%b busy=%b want 00 1", LED_EN, Cal_busy);
    end
    while (Cal_done !== 1'b1 && n < 200) begin
      step();
      n++;
      if (n == 5) Find_setting = 1'b1;
      if (n == 6) Find_setting = 1'b0;
      if (Value_valid != 2'b00) seen_vv = 1'b1;
    end
    checks++;
    if (n != 14) begin
      failures++;
      $display("FAIL lock_done_time got %0d want 14", n);
    end
    checks++;
    if (Cal_fail !== 2'b00 || Cal_busy !== 1'b0 || seen_vv !== 1'b0) begin
      failures++;
      $display("FAIL lock_status got fail=%b busy=%b vv_seen=%b want 00 0 0", Cal_fail, Cal_busy, seen_vv);
    end
    checks++;
    if (LED_DRIVE !== 4'd8 || DC_Comp !== 7'd0 || PGA_Gain !== 4'd0) begin
      failures++;
      $display("FAIL lock_settings got drive=%0d dc=%0d gain=%0d want 8 0 0", LED_DRIVE, DC_Comp, PGA_Gain);
    end
    step();
    checks++;
    if (Cal_done !== 1'b0) begin
      failures++;
      $display("FAIL lock_done_pulse got %b want 0", Cal_done);
    end
  endtask

  task automatic test_cal_dc();
    int n = 0;
    mode = 2;
    start_cal();
    while (Cal_done !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n != 294) begin
      failures++;
      $display("FAIL dc_done_time got %0d want 294", n);
    end
    checks++;
    if (Cal_fail !== 2'b00 || DC_Comp !== 7'd20) begin
      failures++;
      $display("FAIL dc_result got fail=%b dc=%0d want 00 20", Cal_fail, DC_Comp);
    end
    n = 0;
    while (Value_valid !== 2'b10 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (ADC_Value[15:8] !== 8'd160) begin
      failures++;
      $display("FAIL dc_ch1_sample got %0d want 160", ADC_Value[15:8]);
    end
  endtask

  task automatic test_cal_fail();
    int n = 0;
    logic order_bad = 1'b0;
    mode = 0;
    adc_const = 8'd0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start_cal();
    while (Cal_done !== 1'b1 && n < 1000) begin
      step();
      n++;
      if (LED_DRIVE > 4'd8 && PGA_Gain != 4'd15) order_bad = 1'b1;
    end
    checks++;
    if (n != 322) begin
      failures++;
      $display("FAIL fail_done_time got %0d want 322", n);
    end
    checks++;
    if (Cal_fail !== 2'b11 || Cal_busy !== 1'b0) begin
      failures++;
      $display("FAIL fail_flags got fail=%b busy=%b want 11 0", Cal_fail, Cal_busy);
    end
    checks++;
    if (LED_DRIVE !== 4'd15 || PGA_Gain !== 4'd15 || DC_Comp !== 7'd0) begin
      failures++;
      $display("FAIL fail_settings got drive=%0d gain=%0d dc=%0d want 15 15 0", LED_DRIVE, PGA_Gain, DC_Comp);
    end
    checks++;
    if (order_bad !== 1'b0) begin
      failures++;
      $display("FAIL fail_ramp_order got drive rising before gain=15 want gain first");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    adc_const = 8'd130;
    start_cal();
    while (LED_EN === 2'b00 && n < 20) begin
      step();
      n++;
    end
    step();
    checks++;
    if (LED_EN !== 2'b01 || Cal_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got led=%b busy=%b want 01 1", LED_EN, Cal_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (LED_EN !== 2'b00 || Cal_busy !== 1'b0 || Cal_fail !== 2'b00) begin
      failures++;
      $display("FAIL rmid_status got led=%b busy=%b fail=%b want 00 0 00", LED_EN, Cal_busy, Cal_fail);
    end
    checks++;
    if (LED_DRIVE !== 4'd8 || PGA_Gain !== 4'd0 || DC_Comp !== 7'd0) begin
      failures++;
      $display("FAIL rmid_settings got drive=%0d gain=%0d dc=%0d want 8 0 0", LED_DRIVE, PGA_Gain, DC_Comp);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (LED_EN !== 2'b01) begin
      failures++;
      $display("FAIL rmid_restart got %b want 01", LED_EN);
    end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_cal_lock();
    test_cal_dc();
    test_cal_fail();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
